// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// multi-cycle handshake state encoding and the default exception vector.
package pipe_hazard_ctrl_pkg;

    // Fixed front-end stage positions; the back-end positions depend on depth.
    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;

    // Default redirect target for every exception other than ERET.
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    // Multi-cycle unit handshake states.
    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_START = 2'd1,
        MC_WAIT  = 2'd2,
        MC_DONE  = 2'd3
    } mc_state_t;

    // MEM sits two stages before the end of the pipe.
    function automatic int stg_mem(input int nstage);
        return nstage - 2;
    endfunction

    // WB is always the last stage.
    function automatic int stg_wb(input int nstage);
        return nstage - 1;
    endfunction

endpackage

// File: rtl/mc_handshake_fsm.sv
// Start/wait/done handshake with a multi-cycle execution unit (divider,
// multiplier). Holds EX while the unit works and aborts it on an exception.
module mc_handshake_fsm
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mc_op,
    input  logic mc_ready,
    input  logic mem_exc_valid,
    input  logic mem_stall_req,
    output logic mc_start,
    output logic mc_cancel,
    output logic mc_busy,
    output logic mc_stall
);

    mc_state_t state_reg;
    logic      mc_start_reg;
    logic      mc_cancel_reg;
    logic      mc_busy_reg;

    // State register plus registered pulses; an exception always wins and
    // cancels the unit only if it had actually been started.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= MC_IDLE;
            mc_start_reg  <= 1'b0;
            mc_cancel_reg <= 1'b0;
            mc_busy_reg   <= 1'b0;
        end else begin
            mc_start_reg  <= 1'b0;
            mc_cancel_reg <= 1'b0;
            mc_busy_reg   <= 1'b0;
            if (mem_exc_valid) begin
                state_reg     <= MC_IDLE;
                mc_cancel_reg <= (state_reg == MC_START) || (state_reg == MC_WAIT);
            end else begin
                case (state_reg)
                    MC_IDLE: begin
                        // Do not launch while MEM is frozen; EX would not move anyway.
                        if (mc_op && !mem_stall_req) begin
                            state_reg    <= MC_START;
                            mc_start_reg <= 1'b1;
                            mc_busy_reg  <= 1'b1;
                        end
                    end
                    MC_START: begin
                        if (mc_ready) begin
                            state_reg <= MC_DONE;
                        end else begin
                            state_reg   <= MC_WAIT;
                            mc_busy_reg <= 1'b1;
                        end
                    end
                    MC_WAIT: begin
                        if (mc_ready) begin
                            state_reg <= MC_DONE;
                        end else begin
                            mc_busy_reg <= 1'b1;
                        end
                    end
                    // EX advances during DONE, so mc_op here belongs to the finished op.
                    MC_DONE: state_reg <= MC_IDLE;
                    default: state_reg <= MC_IDLE;
                endcase
            end
        end
    end

    assign mc_start  = mc_start_reg;
    assign mc_cancel = mc_cancel_reg;
    assign mc_busy   = mc_busy_reg;

    // EX is held from the moment the op is seen until the result is back.
    assign mc_stall = ((state_reg == MC_IDLE) && mc_op && !mem_exc_valid)
                    || (state_reg == MC_START)
                    || (state_reg == MC_WAIT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: merges per-stage stall requests into stall and
// flush vectors, produces exception/ERET redirects and counts stall cycles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int                 NSTAGE     = 5,
    parameter int                 REG_AW     = 5,
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  EXC_VECTOR = DATA_W'(EXC_VECTOR_DEFAULT),
    parameter int                 CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_rmem,
    input  logic              id_branch_stall,
    input  logic              if_stall_req,
    input  logic              mem_stall_req,
    input  logic              mc_op,
    input  logic              mc_ready,
    output logic              mc_start,
    output logic              mc_cancel,
    output logic              mc_busy,
    input  logic              mem_exc_valid,
    input  logic              mem_eret,
    input  logic [DATA_W-1:0] mem_cp0_epc,
    output logic [DATA_W-1:0] newpc,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int STG_MEM = stg_mem(NSTAGE);

    logic              mc_stall;
    logic              load_use;
    logic [NSTAGE-1:0] req_at;
    logic [NSTAGE-1:0] stall_raw;
    logic [NSTAGE-1:0] flush_raw;
    logic [CNT_W-1:0]  stall_cnt_reg;

    mc_handshake_fsm u_mc_fsm (
        .clk           (clk),
        .rst           (rst),
        .mc_op         (mc_op),
        .mc_ready      (mc_ready),
        .mem_exc_valid (mem_exc_valid),
        .mem_stall_req (mem_stall_req),
        .mc_start      (mc_start),
        .mc_cancel     (mc_cancel),
        .mc_busy       (mc_busy),
        .mc_stall      (mc_stall)
    );

    // A load into a register ID is about to read; $zero never creates a hazard.
    assign load_use = ex_rmem && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // Collect each stall source at the stage that has to hold.
    always_comb begin
        req_at          = '0;
        req_at[STG_IF]  = if_stall_req;
        req_at[STG_ID]  = load_use || id_branch_stall;
        req_at[STG_EX]  = mc_stall;
        req_at[STG_MEM] = mem_stall_req;
    end

    // A request at stage k holds stage k and everything upstream of it; the
    // stage just downstream gets a bubble unless it is itself being held.
    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_stall
            assign stall_raw[gi] = |(req_at >> gi);
        end
        assign flush_raw[0] = 1'b0;
        for (gi = 1; gi < NSTAGE; gi++) begin : g_flush
            assign flush_raw[gi] = req_at[gi-1] && !stall_raw[gi];
        end
    endgenerate

    // An exception squashes the whole pipe and overrides every hold.
    assign stall = mem_exc_valid ? '0 : stall_raw;
    assign flush = mem_exc_valid ? '1 : flush_raw;
    assign newpc = !mem_exc_valid ? '0 : (mem_eret ? mem_cp0_epc : EXC_VECTOR);

    // Count cycles in which fetch is held, sticking at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall[STG_IF] && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    localparam int NSTAGE = 5;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_rmem;
    logic              id_branch_stall;
    logic              if_stall_req;
    logic              mem_stall_req;
    logic              mc_op;
    logic              mc_ready;
    logic              mc_start;
    logic              mc_cancel;
    logic              mc_busy;
    logic              mem_exc_valid;
    logic              mem_eret;
    logic [DATA_W-1:0] mem_cp0_epc;
    logic [DATA_W-1:0] newpc;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic [CNT_W-1:0]  stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(
        .NSTAGE     (NSTAGE),
        .REG_AW     (REG_AW),
        .DATA_W     (DATA_W),
        .EXC_VECTOR (32'hBFC00380),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_rt           (ex_rt),
        .ex_rmem         (ex_rmem),
        .id_branch_stall (id_branch_stall),
        .if_stall_req    (if_stall_req),
        .mem_stall_req   (mem_stall_req),
        .mc_op           (mc_op),
        .mc_ready        (mc_ready),
        .mc_start        (mc_start),
        .mc_cancel       (mc_cancel),
        .mc_busy         (mc_busy),
        .mem_exc_valid   (mem_exc_valid),
        .mem_eret        (mem_eret),
        .mem_cp0_epc     (mem_cp0_epc),
        .newpc           (newpc),
        .stall           (stall),
        .flush           (flush),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic check_sf(input string tag, input logic [4:0] exp_stall, input logic [4:0] exp_flush);
        check_val({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        check_val({tag, "_flush"}, 32'(flush), 32'(exp_flush));
    endtask

    // Inputs change just after the rising edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_rs = '0; id_rt = '0; ex_rt = '0; ex_rmem = 1'b0;
        id_branch_stall = 1'b0; if_stall_req = 1'b0; mem_stall_req = 1'b0;
        mc_op = 1'b0; mc_ready = 1'b0;
        mem_exc_valid = 1'b0; mem_eret = 1'b0; mem_cp0_epc = '0;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();

        // Reset state, outputs observed while reset is still asserted.
        @(negedge clk);
        check_sf("reset", 5'b00000, 5'b00000);
        check_val("reset_newpc", newpc, 32'h0);
        check_val("reset_cnt", 32'(stall_cnt), 32'h0);
        check_val("reset_busy", 32'(mc_busy), 32'h0);
        check_val("reset_start", 32'(mc_start), 32'h0);
        check_val("reset_cancel", 32'(mc_cancel), 32'h0);
        next_cycle();
        rst = 1'b0;

        // Load-use on rs, on rt, and through $zero.
        ex_rmem = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        @(negedge clk); check_sf("lu_rs", 5'b00011, 5'b00100);
        next_cycle();
        id_rs = 5'd7; id_rt = 5'd5;
        @(negedge clk); check_sf("lu_rt", 5'b00011, 5'b00100);
        next_cycle();
        id_rt = 5'd9;
        @(negedge clk); check_sf("lu_nomatch", 5'b00000, 5'b00000);
        next_cycle();
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        @(negedge clk); check_sf("lu_zero", 5'b00000, 5'b00000);
        next_cycle();
        clear_inputs();

        // Individual stall sources.
        id_branch_stall = 1'b1;
        @(negedge clk); check_sf("branch", 5'b00011, 5'b00100);
        next_cycle(); clear_inputs();
        if_stall_req = 1'b1;
        @(negedge clk); check_sf("ifbus", 5'b00001, 5'b00010);
        next_cycle(); clear_inputs();
        mem_stall_req = 1'b1;
        @(negedge clk); check_sf("membus", 5'b01111, 5'b10000);
        next_cycle(); clear_inputs();

        // Load-use together with a data bus stall: no bubble at EX.
        ex_rmem = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; mem_stall_req = 1'b1;
        @(negedge clk); check_sf("lu_mem", 5'b01111, 5'b10000);
        next_cycle(); clear_inputs();

        // Divide: IDLE, START, four WAIT cycles (ready in the last), DONE.
        apply_reset();
        mc_op = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            mc_ready = (c == 5);
            @(negedge clk);
            check_val($sformatf("div_c%0d_stall", c), 32'(stall), (c <= 5) ? 32'h7 : 32'h0);
            check_val($sformatf("div_c%0d_start", c), 32'(mc_start), (c == 1) ? 32'h1 : 32'h0);
            check_val($sformatf("div_c%0d_busy", c), 32'(mc_busy), (c >= 1 && c <= 5) ? 32'h1 : 32'h0);
            next_cycle();
        end
        mc_op = 1'b0; mc_ready = 1'b0;
        @(negedge clk);
        check_val("div_cnt", 32'(stall_cnt), 32'd6);
        check_sf("div_after", 5'b00000, 5'b00000);
        next_cycle();

        // Exception while the unit is in WAIT.
        mc_op = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_val("exc_pre_busy", 32'(mc_busy), 32'h1);
        mem_exc_valid = 1'b1;
        #1;
        check_sf("exc", 5'b00000, 5'b11111);
        check_val("exc_newpc", newpc, 32'hBFC00380);
        check_val("exc_cancel_now", 32'(mc_cancel), 32'h0);
        next_cycle();
        mem_exc_valid = 1'b0; mc_op = 1'b0;
        @(negedge clk);
        check_val("exc_cancel", 32'(mc_cancel), 32'h1);
        check_val("exc_busy", 32'(mc_busy), 32'h0);
        check_sf("exc_idle", 5'b00000, 5'b00000);
        check_val("exc_newpc_clr", newpc, 32'h0);
        next_cycle();
        @(negedge clk);
        check_val("exc_cancel_once", 32'(mc_cancel), 32'h0);
        next_cycle();

        // ERET overriding a concurrent fetch stall; FSM idle so no cancel.
        mem_exc_valid = 1'b1; mem_eret = 1'b1; mem_cp0_epc = 32'h80001234; if_stall_req = 1'b1;
        @(negedge clk);
        check_val("eret_newpc", newpc, 32'h80001234);
        check_sf("eret", 5'b00000, 5'b11111);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check_val("eret_cancel", 32'(mc_cancel), 32'h0);
        next_cycle();

        // Counter saturation with a 4-bit counter, then clear by reset.
        apply_reset();
        if_stall_req = 1'b1;
        for (int i = 0; i < 10; i++) next_cycle();
        @(negedge clk);
        check_val("cnt_10", 32'(stall_cnt), 32'hA);
        for (int i = 0; i < 10; i++) next_cycle();
        @(negedge clk);
        check_val("cnt_sat", 32'(stall_cnt), 32'hF);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; if_stall_req = 1'b0;
        @(negedge clk);
        check_val("cnt_rst", 32'(stall_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the MIPS core. It produces per-stage stall and flush vectors from load-use, branch, bus and multi-cycle-unit requests, plus exception/ERET redirects.
- Adds a sequential handshake FSM for multi-cycle units (divider, multiplier): one-cycle start pulse, busy tracking, and cancel on exception.
- Adds a saturating stall-cycle counter. Sits beside the datapath and drives every pipeline register's stall/flush.

Parameters:
- NSTAGE, 5, number of pipeline stages; index 0=IF, 1=ID, 2=EX, NSTAGE-2=MEM, NSTAGE-1=WB; legal values >=5.
- REG_AW, 5, register-address width.
- DATA_W, 32, PC/EPC width.
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except ERET.
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  REG_AW  ID source registers
- ex_rt  in  REG_AW  EX destination register
- ex_rmem  in  1  EX instruction is a load
- id_branch_stall  in  1  branch operand not ready
- if_stall_req  in  1  instruction bus busy
- mem_stall_req  in  1  data bus busy
- mc_op  in  1  EX holds a multi-cycle op
- mc_ready  in  1  multi-cycle result valid
- mc_start  out  1  one-cycle start pulse to the unit
- mc_cancel  out  1  one-cycle abort pulse to the unit
- mc_busy  out  1  FSM in START or WAIT
- mem_exc_valid  in  1  exception present in MEM
- mem_eret  in  1  the exception is an ERET
- mem_cp0_epc  in  DATA_W  EPC value
- newpc  out  DATA_W  redirect PC
- stall  out  NSTAGE  per-stage hold
- flush  out  NSTAGE  per-stage bubble
- stall_cnt  out  CNT_W  stall-cycle counter

Behaviour:
- Reset: FSM=IDLE; stall_cnt=0; mc_start=mc_cancel=mc_busy=0.
- stall, flush and newpc are combinational. During rst with all inputs low they are 0.
- Generic rule: a stall source at stage k sets stall[0..k] and flush[k+1]. Multiple sources OR together; if any source stalls stage k+1, flush[k+1] is suppressed (a held stage is never bubbled).
- Sources and their stage k:
  - if_stall_req: k=0.
  - Load-use: k=1. Condition is ex_rmem & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
  - id_branch_stall: k=1.
  - mc_stall: k=2.
  - mem_stall_req: k=NSTAGE-2.
- mc_stall = (state==IDLE & mc_op & !mem_exc_valid) | state==START | state==WAIT.
- FSM transitions, all gated by mem_exc_valid having priority:
  - IDLE -> START when mc_op & !mem_exc_valid & !mem_stall_req.
  - START: mc_start=1 for exactly one cycle. Goes to DONE if mc_ready, else WAIT.
  - WAIT -> DONE on mc_ready.
  - DONE: mc_stall=0, so EX advances this cycle; mc_op is ignored. Always goes to IDLE.
- Exception (mem_exc_valid=1):
  - flush = all ones, overriding every stall bit (stall = 0).
  - newpc = mem_eret ? mem_cp0_epc : EXC_VECTOR. newpc = 0 when no exception.
  - FSM goes to IDLE next cycle. mc_cancel=1 for one cycle if the state was START or WAIT.
- stall_cnt increments when stall[0]=1, saturates at all ones, and is cleared only by rst.
- rst mid-operation forces IDLE with no cancel pulse; the unit is reset by the same rst.

Decomposition:
- Shared package: stage-index constants (IF/ID/EX/MEM/WB derived from NSTAGE), FSM state encoding (IDLE, START, WAIT, DONE), EXC_VECTOR default.
- One sub-module: mc_handshake_fsm, containing the FSM, mc_start, mc_cancel, mc_busy and mc_stall.
- Stall/flush vector generation and the counter stay in the top module.

Test Plan:
- Load-use: ex_rmem=1, ex_rt=5, id_rs=5 -> stall=5'b00011, flush=5'b00100. With ex_rt=0 -> stall=0, flush=0.
- Divide: mc_op=1, mc_ready after 4 WAIT cycles -> mc_start high exactly 1 cycle, stall=5'b00111 for 6 cycles, DONE cycle stall=0, stall_cnt=6.
- Exception during WAIT: mem_exc_valid=1, mem_eret=0 -> flush=5'b11111, stall=0, newpc=32'hBFC00380, mc_cancel pulses once, FSM=IDLE next cycle.
- ERET: mem_exc_valid=1, mem_eret=1, mem_cp0_epc=32'h80001234 -> newpc=32'h80001234, flush all ones.
- Simultaneous load-use and mem_stall_req -> stall=5'b01111, flush=5'b10000, with no bubble at EX.
- Counter saturation with CNT_W=4: hold if_stall_req for 20 cycles -> stall_cnt sticks at 4'hF. rst -> 0.
